// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the line memory.
// Owns the instruction pointer, presents it to the memory, and captures the
// returned line into a single-entry valid/ready output stage for decode.
// Stops on the halt sentinel word or when the pointer runs out of range.
module fetch_unit #(
  parameter int                    IP_WIDTH   = 8,
  parameter int                    LINE_WIDTH = 32,
  parameter logic [LINE_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  output logic                  mem_en,
  output logic [IP_WIDTH-1:0]   ip,
  input  logic [LINE_WIDTH-1:0] line,
  output logic [LINE_WIDTH-1:0] instr,
  output logic [IP_WIDTH-1:0]   instr_ip,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  br_take,
  input  logic [IP_WIDTH-1:0]   br_target,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                  state_r,       state_s;
  logic [IP_WIDTH-1:0]     ip_r,          ip_s;
  logic [LINE_WIDTH-1:0]   instr_r,       instr_s;
  logic [IP_WIDTH-1:0]     instr_ip_r,    instr_ip_s;
  logic                    instr_valid_r, instr_valid_s;
  logic                    halted_r,      halted_s;
  logic                    fault_r,       fault_s;
  logic                    mem_en_s;
  logic                    ip_last_s;

  // True when the returned word is the end-of-program sentinel.
  function automatic logic is_halt_word(input logic [LINE_WIDTH-1:0] word);
    return (word == HALT_WORD);
  endfunction

  // Memory is read only when the output slot is free or being drained this
  // cycle, so backpressure never loses a fetched line.
  always_comb begin
    mem_en_s  = (state_r == ST_FETCH) && (!instr_valid_r || instr_ready);
    ip_last_s = (ip_r == {IP_WIDTH{1'b1}});
  end

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_s       = state_r;
    ip_s          = ip_r;
    instr_s       = instr_r;
    instr_ip_s    = instr_ip_r;
    halted_s      = halted_r;
    fault_s       = fault_r;
    // A consume empties the slot unless a capture below refills it.
    if (instr_ready) begin
      instr_valid_s = 1'b0;
    end else begin
      instr_valid_s = instr_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s       = ST_FETCH;
          ip_s          = {IP_WIDTH{1'b0}};
          instr_valid_s = 1'b0;
          halted_s      = 1'b0;
          fault_s       = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (br_take) begin
          // Redirect wins over any capture, halt or overflow this cycle.
          ip_s          = br_target;
          instr_valid_s = 1'b0;
        end else if (mem_en_s) begin
          if (is_halt_word(line)) begin
            // Sentinel is never forwarded; ip stays on its address.
            state_s  = ST_HALT;
            halted_s = 1'b1;
            fault_s  = 1'b0;
          end else begin
            instr_s       = line;
            instr_ip_s    = ip_r;
            instr_valid_s = 1'b1;
            if (ip_last_s) begin
              // Last address consumed: stop instead of wrapping to 0.
              state_s  = ST_HALT;
              halted_s = 1'b1;
              fault_s  = 1'b1;
            end else begin
              ip_s = ip_r + IP_WIDTH'(1);
            end
          end
        end else begin
          state_s = ST_FETCH;
        end
      end

      ST_HALT: begin
        if (start) begin
          state_s       = ST_FETCH;
          ip_s          = {IP_WIDTH{1'b0}};
          instr_valid_s = 1'b0;
          halted_s      = 1'b0;
          fault_s       = 1'b0;
        end else if (br_take) begin
          // A halt reached down a mispredicted path is cancelled.
          state_s       = ST_FETCH;
          ip_s          = br_target;
          instr_valid_s = 1'b0;
          halted_s      = 1'b0;
          fault_s       = 1'b0;
        end else begin
          state_s = ST_HALT;
        end
      end

      default: begin
        state_s       = ST_IDLE;
        ip_s          = {IP_WIDTH{1'b0}};
        instr_valid_s = 1'b0;
        halted_s      = 1'b0;
        fault_s       = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      ip_r          <= {IP_WIDTH{1'b0}};
      instr_r       <= {LINE_WIDTH{1'b0}};
      instr_ip_r    <= {IP_WIDTH{1'b0}};
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      ip_r          <= ip_s;
      instr_r       <= instr_s;
      instr_ip_r    <= instr_ip_s;
      instr_valid_r <= instr_valid_s;
      halted_r      <= halted_s;
      fault_r       <= fault_s;
    end
  end

  assign mem_en      = mem_en_s;
  assign ip          = ip_r;
  assign instr       = instr_r;
  assign instr_ip    = instr_ip_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table on an 8-bit
// instance (stream, halt, restart, backpressure, branch, reset mid-run) and a
// hand-written overflow sequence on a 4-bit instance.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit pointer instance and its line memory
  logic        n_rst, start, instr_ready, br_take;
  logic [7:0]  br_target, ip, instr_ip;
  logic [31:0] line, instr;
  logic        mem_en, instr_valid, halted, fault;
  logic [31:0] mem8 [256];

  assign line = mem8[ip];

  fetch_unit #(.IP_WIDTH(8), .LINE_WIDTH(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .mem_en(mem_en), .ip(ip),
    .line(line), .instr(instr), .instr_ip(instr_ip), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_take(br_take), .br_target(br_target),
    .halted(halted), .fault(fault)
  );

  // 4-bit pointer instance, memory holds 0x5 everywhere (no sentinel)
  logic        n_rst4, start4, ready4, br4;
  logic [3:0]  tgt4, ip4, iip4;
  logic [31:0] line4, instr4;
  logic        mem_en4, valid4, halted4, fault4;

  assign line4 = 32'h0000_0005;

  fetch_unit #(.IP_WIDTH(4), .LINE_WIDTH(32), .HALT_WORD(32'hFFFF_FFFF)) dut4 (
    .clk(clk), .n_rst(n_rst4), .start(start4), .mem_en(mem_en4), .ip(ip4),
    .line(line4), .instr(instr4), .instr_ip(iip4), .instr_valid(valid4),
    .instr_ready(ready4), .br_take(br4), .br_target(tgt4),
    .halted(halted4), .fault(fault4)
  );

  typedef struct {
    logic        rst_n_v;
    logic        start_v;
    logic        rdy_v;
    logic        br_v;
    logic [7:0]  tgt_v;
    logic        e_mem_en;
    logic [7:0]  e_ip;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [7:0]  e_iip;
    logic        e_halted;
    logic        e_fault;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic b, input logic [7:0] t,
                              input logic me, input logic [7:0] eip,
                              input logic ev, input logic [31:0] ei,
                              input logic [7:0] eiip, input logic eh,
                              input logic ef);
    vec_t v;
    v.rst_n_v = r;  v.start_v = s; v.rdy_v = rd; v.br_v = b; v.tgt_v = t;
    v.e_mem_en = me; v.e_ip = eip; v.e_valid = ev; v.e_instr = ei;
    v.e_iip = eiip; v.e_halted = eh; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    // Program: 0x11,0x22,0x33,HALT at 0..3; 0xAB at 0x10; filler elsewhere
    for (int i = 0; i < 256; i++) mem8[i] = 32'h0000_1000 + 32'(i);
    mem8[0]     = 32'h0000_0011;
    mem8[1]     = 32'h0000_0022;
    mem8[2]     = 32'h0000_0033;
    mem8[3]     = 32'hFFFF_FFFF;
    mem8[8'h10] = 32'h0000_00AB;

    // Inputs applied in a cycle; expectations are the outputs in that cycle,
    // sampled before its closing rising edge.
    //            rst st rdy br tgt    | me ip     v  instr          iip    h  f
    vecs[0]  = mk(1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,32'h00,8'h00,1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00,1'b0,32'h00,8'h00,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h01,1'b1,32'h11,8'h00,1'b0,1'b0);
    vecs[3]  = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h02,1'b1,32'h22,8'h01,1'b0,1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h03,1'b1,32'h33,8'h02,1'b0,1'b0);
    vecs[5]  = mk(1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h03,1'b0,32'h33,8'h02,1'b1,1'b0);
    vecs[6]  = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00,1'b0,32'h33,8'h02,1'b0,1'b0);
    vecs[7]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h01,1'b1,32'h11,8'h00,1'b0,1'b0);
    vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h01,1'b1,32'h11,8'h00,1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h01,1'b1,32'h11,8'h00,1'b0,1'b0);
    vecs[10] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h01,1'b1,32'h11,8'h00,1'b0,1'b0);
    vecs[11] = mk(1'b1,1'b0,1'b1,1'b1,8'h10, 1'b1,8'h02,1'b1,32'h22,8'h01,1'b0,1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h10,1'b0,32'h22,8'h01,1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b0,1'b1,1'b1,8'h01, 1'b1,8'h11,1'b1,32'hAB,8'h10,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h01,1'b0,32'hAB,8'h10,1'b0,1'b0);
    vecs[15] = mk(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h02,1'b1,32'h22,8'h01,1'b0,1'b0);
    vecs[16] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,32'h00,8'h00,1'b0,1'b0);
    vecs[17] = mk(1'b1,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,32'h00,8'h00,1'b0,1'b0);
    vecs[18] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00,1'b0,32'h00,8'h00,1'b0,1'b0);
    vecs[19] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h01,1'b1,32'h11,8'h00,1'b0,1'b0);

    n_rst = 1'b0; start = 1'b0; instr_ready = 1'b0; br_take = 1'b0;
    br_target = 8'h00;
    n_rst4 = 1'b0; start4 = 1'b0; ready4 = 1'b0; br4 = 1'b0; tgt4 = 4'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      n_rst       = vecs[i].rst_n_v;
      start       = vecs[i].start_v;
      instr_ready = vecs[i].rdy_v;
      br_take     = vecs[i].br_v;
      br_target   = vecs[i].tgt_v;
      #1;
      check($sformatf("vec%0d{me,ip,v,instr,iip,h,f}", i),
            64'({mem_en, ip, instr_valid, instr, instr_ip, halted, fault}),
            64'({vecs[i].e_mem_en, vecs[i].e_ip, vecs[i].e_valid, vecs[i].e_instr,
                 vecs[i].e_iip, vecs[i].e_halted, vecs[i].e_fault}));
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0; instr_ready = 1'b0; br_take = 1'b0;

    // Overflow: 16 words delivered, then HALT with fault and ip pinned at 0xF
    n_rst4 = 1'b1; start4 = 1'b1; ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && !(halted4 && !valid4); c++) begin
      if (valid4) begin
        check($sformatf("ovf_word%0d{iip,instr}", cnt),
              64'({iip4, instr4}), 64'({4'(cnt), 32'h0000_0005}));
        cnt++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("ovf_count", 64'(cnt), 64'd16);
    check("ovf_end{h,f,ip,me,v}", 64'({halted4, fault4, ip4, mem_en4, valid4}),
          64'({1'b1, 1'b1, 4'hF, 1'b0, 1'b0}));

    // Branch while halted returns to FETCH and clears halted/fault
    br4 = 1'b1; tgt4 = 4'h3;
    @(posedge clk);
    @(negedge clk);
    br4 = 1'b0;
    check("halt_branch{h,f,ip,me}", 64'({halted4, fault4, ip4, mem_en4}),
          64'({1'b0, 1'b0, 4'h3, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the line memory. Owns the instruction pointer and drives the memory's `en`/`ip` inputs, then registers the returned 32-bit line into a single-entry output stage with a valid/ready handshake toward decode. Handles branch redirects from decode, and stops the CPU on the halt sentinel word or on instruction-pointer exhaustion.

## Interface
Parameters:
- `IP_WIDTH`, 8: instruction pointer width; matches line memory address width.
- `LINE_WIDTH`, 32: instruction word width.
- `HALT_WORD`, 32'hFFFFFFFF: sentinel word that ends the program.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `n_rst`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  begin execution at ip 0; honored only in IDLE or HALT.
- `mem_en`  out  1  enable to line memory.
- `ip`  out  IP_WIDTH  address to line memory.
- `line`  in  LINE_WIDTH  word returned by line memory; valid in the same cycle `mem_en`=1.
- `instr`  out  LINE_WIDTH  registered instruction to decode.
- `instr_ip`  out  IP_WIDTH  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `br_take`  in  1  redirect request; decode asserts it only in a cycle where it accepts an instruction.
- `br_target`  in  IP_WIDTH  redirect address.
- `halted`  out  1  FSM is in HALT.
- `fault`  out  1  halt caused by ip exhaustion rather than `HALT_WORD`.

## Operation
- States: IDLE, FETCH, HALT.
- Reset (`n_rst`=0 at an edge): state IDLE, `ip`=0, `instr`=0, `instr_ip`=0, `instr_valid`=0, `halted`=0, `fault`=0. Reset overrides every other input, including mid-fetch and in HALT.
- `mem_en` is combinational. It is 1 only when state=FETCH and (`instr_valid`=0 or `instr_ready`=1). It is 0 in IDLE and HALT.
- IDLE: `start`=1 causes a transition to FETCH with `ip`=0.
- FETCH, capture cycle (`mem_en`=1):
  - Without a branch: `instr`<=`line`, `instr_ip`<=`ip`, `instr_valid`<=1, `ip`<=`ip`+1.
  - Exception: if `line`==`HALT_WORD`, it is not forwarded. `instr_valid` is cleared if decode consumed the current entry, otherwise it is kept. `ip` is frozen at the sentinel address, and state goes to HALT with `fault`=0.
  - Exception: if `ip` is all-ones and `line`!=`HALT_WORD`, the word is captured normally, `ip` does not increment (no wrap), and state goes to HALT with `fault`=1.
- FETCH, stall (`instr_valid`=1, `instr_ready`=0): all registers hold and `ip` is unchanged.
- Consume without capture (`instr_ready`=1 while not capturing): `instr_valid`<=0.
- Branch (`br_take`=1, any state except IDLE): `ip`<=`br_target` and `instr_valid`<=0.
  - The word captured that cycle, if any, is discarded.
  - Branch takes priority over halt detection and the overflow fault in the same cycle.
  - In HALT, a branch returns the FSM to FETCH and clears `halted`/`fault`, so a halt word fetched speculatively after a taken branch is never acted on.
- HALT: `halted`=1. `instr_valid` may remain 1 until decode drains the last real instruction. `start`=1 restarts: `ip`=0, `instr_valid`=0, `fault`=0, state FETCH.
- `br_target` is used as-is; there is no range checking.

## Timing
- Start latency: `start` sampled at edge E0. FETCH with `mem_en`=1, `ip`=0 during cycle E0–E1. `instr`=code[0] and `instr_valid`=1 after E1.
- Throughput is one instruction per cycle while `instr_ready`=1.
- Branch penalty is one bubble. `br_take` at edge E, target fetched in cycle E–E+1, `instr_valid`=1 after E+1.
- Halt is observed one cycle after the sentinel address is presented: `halted`=1 after the capture edge.
- Backpressure is applied same-cycle: `instr_ready`=0 forces `mem_en`=0 in that cycle, so no line is lost.

## Test plan
- Stream: memory holds 0x11,0x22,0x33,HALT_WORD at ip 0–3; `start` pulse with `instr_ready`=1. Required: `instr` 0x11/0x22/0x33 on consecutive cycles with `instr_ip` 0/1/2, then `halted`=1, `fault`=0, `ip`=3, and `instr_valid` never shows HALT_WORD.
- Backpressure: same program with `instr_ready` held 0 for 3 cycles after the first valid. Required: `instr`=0x11 held, `mem_en`=0, `ip`=1 throughout; the stream resumes without loss or duplication.
- Branch: decode accepts ip 1 with `br_take`=1 and `br_target`=0x10 (word 0xAB). Required: the word at ip 2 is never valid; the next valid is `instr`=0xAB with `instr_ip`=0x10.
- Overflow: `IP_WIDTH`=4, no sentinel, all words 0x5. Required: 16 instructions delivered, then `halted`=1, `fault`=1, `ip`=4'hF.
- Reset mid-run: `n_rst`=0 for one edge while `instr_valid`=1 and `ip`=2. Required: all outputs return to reset values, IDLE holds until `start`, and restart fetches from ip 0.
- Restart from HALT: pulse `start` while `halted`=1. Required: `halted`/`fault` clear on the next edge and code[0] reappears one cycle later.
